// File: rtl/ram8_pkg.sv
// ram8_pkg: shared definitions for the 8x16 RAM burst initiator.
//   - default data width and address width of the RAM port
//   - PROFUNDIDADE: number of words in the RAM
//   - estado_t: state encoding of the burst FSM in mestre_ram8
package ram8_pkg;

    localparam int LARGURA_PADRAO  = 16;
    localparam int BITS_END_PADRAO = 3;
    localparam int PROFUNDIDADE    = 8;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        LER      = 3'd1,
        ENTREGA  = 3'd2,
        ESCREVER = 3'd3,
        FIM      = 3'd4
    } estado_t;

endpackage

// File: rtl/mestre_ram8_contador_endereco.sv
// contador_endereco: address counter with load and natural-wrap increment.
// Shared by the RAM burst initiator and the program-counter path.
//   relogio_in     clock, rising edge
//   reinicia_in    asynchronous active-high reset, clears the count to 0
//   carrega_in     load base_in (takes priority over increment)
//   base_in        value to load
//   incrementa_in  advance by one, wrapping from all-ones to 0
//   valor_out      current count
module contador_endereco #(
    parameter int BITS = 3
) (
    input  logic            relogio_in,
    input  logic            reinicia_in,
    input  logic            carrega_in,
    input  logic [BITS-1:0] base_in,
    input  logic            incrementa_in,
    output logic [BITS-1:0] valor_out
);

    // NOTE: clocked state uses <= so every register samples pre-edge values;
    // a blocking = here would make the result depend on process ordering.
    always_ff @(posedge relogio_in or posedge reinicia_in) begin
        if (reinicia_in) begin
            valor_out <= '0;
        end else if (carrega_in) begin
            valor_out <= base_in;
        end else if (incrementa_in) begin
            valor_out <= valor_out + BITS'(1);
        end
    end

endmodule

// File: rtl/mestre_ram8.sv
// mestre_ram8: burst initiator for the 8x16 RAM (minha_ram8).
// A command in OCIOSO starts a read or write burst of 1..8 words from a base
// address, wrapping at the top of the RAM.
//   relogio_in / reinicia_in          clock, async active-high reset
//   inicio_in, modo_in, base_in,
//   quantidade_in                     command (modo 0 = read, 1 = write)
//   dado_in, dado_valido_in,
//   dado_pronto_out                   write-data stream (slave side)
//   dado_out, dado_valido_out,
//   dado_pronto_in                    read-data stream (registered master side)
//   ram_endereco_out, ram_dado_out,
//   ram_habilita_out, ram_dado_in     RAM port (combinational read)
//   ocupado_out                       high whenever a burst is in progress
//   concluido_out                     one-cycle pulse when a burst finishes
module mestre_ram8
    import ram8_pkg::*;
#(
    parameter int LARGURA  = LARGURA_PADRAO,
    parameter int BITS_END = BITS_END_PADRAO
) (
    input  logic                relogio_in,
    input  logic                reinicia_in,
    input  logic                inicio_in,
    input  logic                modo_in,
    input  logic [BITS_END-1:0] base_in,
    input  logic [BITS_END:0]   quantidade_in,
    input  logic [LARGURA-1:0]  dado_in,
    input  logic                dado_valido_in,
    output logic                dado_pronto_out,
    output logic [LARGURA-1:0]  dado_out,
    output logic                dado_valido_out,
    input  logic                dado_pronto_in,
    output logic [BITS_END-1:0] ram_endereco_out,
    output logic [LARGURA-1:0]  ram_dado_out,
    output logic                ram_habilita_out,
    input  logic [LARGURA-1:0]  ram_dado_in,
    output logic                ocupado_out,
    output logic                concluido_out
);

    // Longest burst: the whole RAM.
    localparam logic [BITS_END:0] MAXIMO = (BITS_END+1)'(2**BITS_END);
    localparam logic [BITS_END:0] UM     = (BITS_END+1)'(1);

    estado_t             estado, estado_prox;
    logic [BITS_END:0]   restante, restante_prox;
    logic [BITS_END-1:0] pc;
    logic                carrega, incrementa;
    logic                captura, libera;
    logic                escrevendo;

    contador_endereco #(
        .BITS (BITS_END)
    ) u_pc (
        .relogio_in    (relogio_in),
        .reinicia_in   (reinicia_in),
        .carrega_in    (carrega),
        .base_in       (base_in),
        .incrementa_in (incrementa),
        .valor_out     (pc)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        estado_prox   = estado;
        restante_prox = restante;
        carrega       = 1'b0;
        incrementa    = 1'b0;
        captura       = 1'b0;
        libera        = 1'b0;
        case (estado)
            OCIOSO: begin
                // A zero-length command is dropped without leaving OCIOSO.
                if (inicio_in && (quantidade_in != '0)) begin
                    carrega       = 1'b1;
                    restante_prox = (quantidade_in > MAXIMO) ? MAXIMO : quantidade_in;
                    estado_prox   = modo_in ? ESCREVER : LER;
                end
            end
            LER: begin
                captura     = 1'b1;
                estado_prox = ENTREGA;
            end
            ENTREGA: begin
                if (dado_pronto_in) begin
                    libera        = 1'b1;
                    incrementa    = 1'b1;
                    restante_prox = restante - UM;
                    estado_prox   = (restante == UM) ? FIM : LER;
                end
            end
            ESCREVER: begin
                if (dado_valido_in) begin
                    incrementa    = 1'b1;
                    restante_prox = restante - UM;
                    if (restante == UM) begin
                        estado_prox = FIM;
                    end
                end
            end
            FIM: begin
                estado_prox = OCIOSO;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge relogio_in or posedge reinicia_in) begin
        if (reinicia_in) begin
            estado          <= OCIOSO;
            restante        <= '0;
            dado_out        <= '0;
            dado_valido_out <= 1'b0;
        end else begin
            estado   <= estado_prox;
            restante <= restante_prox;
            // The read word is held until the consumer takes it.
            if (captura) begin
                dado_out        <= ram_dado_in;
                dado_valido_out <= 1'b1;
            end else if (libera) begin
                dado_valido_out <= 1'b0;
            end
        end
    end

    assign escrevendo       = (estado == ESCREVER);
    assign dado_pronto_out  = escrevendo;
    assign ram_habilita_out = escrevendo & dado_valido_in;
    assign ram_dado_out     = escrevendo ? dado_in : '0;
    assign ram_endereco_out = pc;
    assign ocupado_out      = (estado != OCIOSO);
    assign concluido_out    = (estado == FIM);

endmodule
